npu_wb_array: RTL and testbench

Parametrised Wishbone-attached weight-stationary systolic NPU, successor to the fixed 3x3 NPU peripheral on the Caravel bus. It holds an N x N signed weight matrix, buffers up to DEPTH input vectors, and computes the batch on a start command. Results go to a readable result buffer, with busy/done/error status. Everything runs on the Wishbone clock; there is no separate array clock.

---
 rtl/npu_wb_array.sv | 228 ++++++++++++++++++++++
 tb/tb_npu_wb_array.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_wb_array.sv
// Wishbone-attached weight-stationary systolic NPU.
// Holds an N x N signed weight matrix and buffers up to DEPTH input vectors.
// A start command streams the batch through the array and fills a readable
// result buffer. Busy/done/ovf/err status is readable over the bus.
// Bus handshake: a transfer is accepted on the edge where stb & cyc & region
// hit are high and ack is low; that edge raises ack for exactly one cycle and
// registers read data, so a held strobe is acked every other cycle.
module npu_wb_array #(
  parameter logic [23:0] BASE_ADDR = 24'h3000_00,
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int ACC_W = 20,
  parameter int DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  input  logic [31:0] wb_adr_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o
);

  localparam int NN  = N * N;
  localparam int NR  = DEPTH * N;
  localparam int DAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAW = $clog2(NN);
  localparam int RAW = $clog2(NR);
  localparam int KW  = $clog2(DEPTH + 2 * N + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

  state_t state, state_nx;

  logic hit, acc, wr;
  logic [5:0] word;
  logic is_ctrl, is_stat, is_vec, is_w, is_res;
  logic [WAW-1:0] widx;
  logic [RAW-1:0] ridx;
  logic unused_bits;

  logic start_q, done, ovf, err, busy;
  logic [3:0] in_cnt, out_cnt;
  logic [KW-1:0] k;
  logic last_feed, last_drain, row_done;
  logic [3:0] row_cnt;
  logic [31:0] rd_data;

  logic signed [DW-1:0]    w_q    [NN];
  logic [N*DW-1:0]         in_buf [DEPTH];
  logic signed [ACC_W-1:0] res_q  [NR];
  logic signed [DW-1:0]    x_in   [N];
  logic signed [DW-1:0]    xa     [N][N];
  logic signed [ACC_W-1:0] ps     [N][N];

  assign hit  = wb_stb_i & wb_cyc_i & (wb_adr_i[31:8] == BASE_ADDR);
  assign acc  = hit & ~wb_ack_o;
  assign wr   = acc & wb_we_i;
  assign word = wb_adr_i[7:2];
  assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

  assign is_ctrl = (word == 6'd0);
  assign is_stat = (word == 6'd1);
  assign is_vec  = (word == 6'd2);
  assign is_w    = (word[5:4] == 2'b01) && (int'(word[3:0]) < NN);
  assign is_res  = word[5] && (int'(word[4:0]) < NR);
  assign widx    = word[WAW-1:0];
  assign ridx    = word[RAW-1:0];

  assign busy       = (state != S_IDLE);
  assign last_feed  = (state == S_FEED)  && (int'(k) == int'(in_cnt) - 1);
  assign last_drain = (state == S_DRAIN) && (int'(k) == int'(in_cnt) + 2 * N - 1);
  // Bottom of the last column carries vector k-(2N-1) in cycle k.
  assign row_done   = busy && (int'(k) >= 2 * N - 1) &&
                      (int'(k) - (2 * N - 1) < int'(in_cnt));
  assign row_cnt    = 4'(int'(k) - 2 * N + 2);

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic: FEED lasts M cycles, DRAIN lasts 2N cycles.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_q && (in_cnt != 4'd0)) state_nx = S_FEED;
      S_FEED:  if (last_feed)  state_nx = S_DRAIN;
      S_DRAIN: if (last_drain) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Cycle index across FEED and DRAIN; zero on the first FEED cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)              k <= '0;
    else if (state == S_IDLE)  k <= '0;
    else                       k <= k + 1'b1;
  end

  // Control, counters and sticky flags.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      start_q <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      start_q <= wr && is_ctrl && wb_dat_i[0] && !busy;
      if (wr && is_ctrl && wb_dat_i[1]) begin
        if (busy) err <= 1'b1;
        else begin
          in_cnt  <= '0;
          out_cnt <= '0;
          done    <= 1'b0;
          ovf     <= 1'b0;
          err     <= 1'b0;
        end
      end
      if (wr && is_vec) begin
        if (busy)                          err    <= 1'b1;
        else if (int'(in_cnt) == DEPTH)    ovf    <= 1'b1;
        else                               in_cnt <= in_cnt + 4'd1;
      end
      if (wr && is_w && busy) err <= 1'b1;
      if ((state == S_IDLE) && start_q) begin
        if (in_cnt == 4'd0) done <= 1'b1;
        else begin
          done    <= 1'b0;
          out_cnt <= '0;
        end
      end
      if (row_done) out_cnt <= row_cnt;
      if (last_drain) begin
        out_cnt <= in_cnt;
        in_cnt  <= '0;
        done    <= 1'b1;
      end
    end
  end

  // Weight registers, writable only while idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int n = 0; n < NN; n++) w_q[n] <= '0;
    end else if (wr && is_w && !busy) begin
      w_q[widx] <= wb_dat_i[DW-1:0];
    end
  end

  // Skewed row inputs: row i sees vector k-i in cycle k.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_in[i] = '0;
      if (busy && (int'(k) >= i) && (int'(k) - i < int'(in_cnt)))
        x_in[i] = in_buf[DAW'(int'(k) - i)][i*DW +: DW];
    end
  end

  // Processing elements: x moves right, partial sums move down.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [DW-1:0]    xop;
      logic signed [ACC_W-1:0] top;
      logic signed [2*DW-1:0]  prod;
      if (gj == 0) begin : g_xl
        assign xop = x_in[gi];
      end else begin : g_xr
        assign xop = xa[gi][gj-1];
      end
      if (gi == 0) begin : g_pt
        assign top = '0;
      end else begin : g_pb
        assign top = ps[gi-1][gj];
      end
      assign prod = xop * w_q[gi*N+gj];
      // Register the passing input and the accumulated partial sum.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          xa[gi][gj] <= '0;
          ps[gi][gj] <= '0;
        end else begin
          xa[gi][gj] <= xop;
          ps[gi][gj] <= top + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        end
      end
    end
  end

  // Input buffer push and de-skewed result capture (column j lags by j).
  always_ff @(posedge wb_clk_i) begin
    if (wr && is_vec && !busy && (int'(in_cnt) != DEPTH))
      in_buf[in_cnt[DAW-1:0]] <= wb_dat_i[N*DW-1:0];
    for (int j = 0; j < N; j++) begin
      if (busy && (int'(k) >= N + j) && (int'(k) - N - j < int'(in_cnt)))
        res_q[RAW'((int'(k) - N - j) * N + j)] <= ps[N-1][j];
    end
  end

  // Read mux; results beyond out_cnt read as zero.
  always_comb begin
    rd_data = '0;
    if (is_stat)
      rd_data = {12'd0, out_cnt, 4'd0, in_cnt, 4'd0, err, ovf, done, busy};
    else if (is_w)
      rd_data = {{(32-DW){w_q[widx][DW-1]}}, w_q[widx]};
    else if (is_res && (int'(ridx) < int'(out_cnt) * N))
      rd_data = {{(32-ACC_W){res_q[ridx][ACC_W-1]}}, res_q[ridx]};
  end

  // Bus ack pulse and registered read data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= (acc && !wb_we_i) ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_npu_wb_array.sv
// Directed bench for npu_wb_array: bus driver tasks, one task per scenario,
// expected result queue for the batch buffers, and a final summary line.
module tb_npu_wb_array;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;

  int unsigned cyc_n = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned last_ack = 0;
  int          w_model [9];
  logic [31:0] vecs [9];
  logic [31:0] exp_q [$];

  npu_wb_array dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_stb_i(stb), .wb_cyc_i(cyc),
    .wb_we_i(we), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_adr_i(adr),
    .wb_ack_o(ack), .wb_dat_o(dat_o)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Result RES[m][j] = sum_i x[m][i]*W[i][j], wrapped to 20 bits, sign-extended.
  function automatic logic [31:0] model_res(input logic [31:0] v, input int j);
    int s;
    logic [19:0] tr;
    s = 0;
    for (int i = 0; i < 3; i++) s += int'($signed(v[i*8 +: 8])) * w_model[i*3+j];
    tr = s[19:0];
    return {{12{tr[19]}}, tr};
  endfunction

  // Driver: one transfer, called at a falling edge; returns at the ack falling edge.
  task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                         output logic [31:0] q);
    int n;
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | {24'd0, off}; dat_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    q = dat_o;
    last_ack = cyc_n;
    if (!ack) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_timeout off=%h got ack=0 want ack=1", off);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, off, d, q);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] q);
    wb_xfer(1'b0, off, 32'd0, q);
  endtask

  // Read whose ack lands exactly on edge e.
  task automatic read_at(input logic [7:0] off, input int unsigned e, output logic [31:0] q);
    while (cyc_n < e - 1) @(negedge clk);
    wb_read(off, q);
    n_cmp++;
    if (last_ack !== e) begin
      n_fail++;
      $display("FAIL read_at_edge off=%h got edge %0d want %0d", off, last_ack, e);
    end
  endtask

  task automatic load_weights();
    for (int n = 0; n < 9; n++) wb_write(8'(8'h40 + 4 * n), 32'(w_model[n]));
  endtask

  // Poll STATUS until done and not busy.
  task automatic wait_done();
    logic [31:0] q;
    int n;
    n = 0;
    do begin
      wb_read(8'h04, q);
      n++;
    end while (!(q[1] && !q[0]) && n < 40);
    n_cmp++;
    if (!(q[1] && !q[0])) begin
      n_fail++;
      $display("FAIL done_timeout status got %h want done=1 busy=0", q);
    end
  endtask

  task automatic test_reset();
    logic [31:0] q;
    n_cmp++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL por_ack got %b want 0", ack); end
    n_cmp++;
    if (dat_o !== 32'd0) begin n_fail++; $display("FAIL por_dat got %h want 0", dat_o); end
    rst = 1'b0;
    @(negedge clk);
    wb_write(8'h40, 32'd5);
    wb_write(8'h08, 32'h0001_0203);
    wb_read(8'h04, q);
    n_cmp++;
    if (q !== 32'h0000_0100) begin n_fail++; $display("FAIL pre_reset_status got %h want 00000100", q); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0", ack); end
    n_cmp++;
    if (dat_o !== 32'd0) begin n_fail++; $display("FAIL rst_dat got %h want 0", dat_o); end
    rst = 1'b0;
    @(negedge clk);
    wb_read(8'h04, q);
    n_cmp++;
    if (q !== 32'd0) begin n_fail++; $display("FAIL rst_status got %h want 00000000", q); end
    wb_read(8'h40, q);
    n_cmp++;
    if (q !== 32'd0) begin n_fail++; $display("FAIL rst_w00 got %h want 00000000", q); end
  endtask

  task automatic test_identity();
    logic [31:0] q;
    int unsigned t;
    logic [31:0] exp_r [3];
    exp_r = '{32'd1, 32'd2, 32'd3};
    w_model = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    load_weights();
    wb_write(8'h08, 32'h0003_0201);
    wb_write(8'h00, 32'd1);
    t = last_ack;
    read_at(8'h04, t + 2, q);
    n_cmp++;
    if (q !== 32'h0000_0101) begin n_fail++; $display("FAIL id_busy_first got %h want 00000101", q); end
    read_at(8'h04, t + 8, q);
    n_cmp++;
    if (q !== 32'h0001_0101) begin n_fail++; $display("FAIL id_busy_last got %h want 00010101", q); end
    read_at(8'h04, t + 10, q);
    n_cmp++;
    if (q !== 32'h0001_0002) begin n_fail++; $display("FAIL id_done got %h want 00010002", q); end
    for (int j = 0; j < 3; j++) begin
      wb_read(8'(8'h80 + 4 * j), q);
      n_cmp++;
      if (q !== exp_r[j]) begin n_fail++; $display("FAIL id_res0_%0d got %h want %h", j, q, exp_r[j]); end
    end
  endtask

  task automatic test_signed_extreme();
    logic [31:0] q;
    for (int n = 0; n < 9; n++) wb_write(8'(8'h40 + 4 * n), 32'hFFFF_FF80);
    wb_write(8'h08, 32'h5A80_8080);
    wb_write(8'h00, 32'd1);
    wait_done();
    for (int j = 0; j < 3; j++) begin
      wb_read(8'(8'h80 + 4 * j), q);
      n_cmp++;
      if (q !== 32'h0000_C000) begin n_fail++; $display("FAIL sx_res0_%0d got %h want 0000c000", j, q); end
    end
    wb_read(8'h50, q);
    n_cmp++;
    if (q !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL sx_w11 got %h want ffffff80", q); end
  endtask

  task automatic test_clear();
    logic [31:0] q;
    wb_write(8'h00, 32'd2);
    wb_read(8'h04, q);
    n_cmp++;
    if (q !== 32'd0) begin n_fail++; $display("FAIL clear_status got %h want 00000000", q); end
  endtask

  task automatic test_batch();
    logic [31:0] q, e;
    int unsigned t;
    w_model = '{1, -2, 3, -4, 5, -6, 7, -8, -128};
    load_weights();
    for (int m = 0; m < 9; m++) wb_write(8'h08, vecs[m]);
    wb_read(8'h04, q);
    n_cmp++;
    if (q !== 32'h0000_0804) begin n_fail++; $display("FAIL batch_pre_status got %h want 00000804", q); end
    wb_write(8'h00, 32'd1);
    t = last_ack;
    read_at(8'h04, t + 2, q);
    n_cmp++;
    if (q !== 32'h0000_0805) begin n_fail++; $display("FAIL batch_busy_first got %h want 00000805", q); end
    read_at(8'h04, t + 14, q);
    n_cmp++;
    if (q !== 32'h0007_0805) begin n_fail++; $display("FAIL batch_busy_late got %h want 00070805", q); end
    read_at(8'h04, t + 16, q);
    n_cmp++;
    if (q !== 32'h0008_0006) begin n_fail++; $display("FAIL batch_idle got %h want 00080006", q); end
    for (int m = 0; m < 8; m++)
      for (int j = 0; j < 3; j++) exp_q.push_back(model_res(vecs[m], j));
    for (int n = 0; n < 24; n++) begin
      wb_read(8'(8'h80 + 4 * n), q);
      e = exp_q.pop_front();
      n_cmp++;
      if (q !== e) begin n_fail++; $display("FAIL batch_res_%0d got %h want %h", n, q, e); end
    end
    wb_read(8'hE0, q);
    n_cmp++;
    if (q !== 32'd0) begin n_fail++; $display("FAIL batch_res8_0 got %h want 00000000", q); end
  endtask

  task automatic test_hazards();
    logic [31:0] q, e;
    int unsigned t;
    wb_write(8'h00, 32'd2);
    wb_write(8'h08, vecs[0]);
    wb_write(8'h08, vecs[1]);
    wb_write(8'h00, 32'd1);
    t = last_ack;
    wb_write(8'h40, 32'h0000_0055);
    wb_write(8'h00, 32'd1);
    wb_read(8'h0C, q);
    n_cmp++;
    if (q !== 32'd0 || last_ack !== t + 6) begin
      n_fail++;
      $display("FAIL hz_unmapped got %h at edge %0d want 00000000 at edge %0d", q, last_ack, t + 6);
    end
    read_at(8'h04, t + 9, q);
    n_cmp++;
    if (q !== 32'h0002_0209) begin n_fail++; $display("FAIL hz_busy_last got %h want 00020209", q); end
    read_at(8'h04, t + 11, q);
    n_cmp++;
    if (q !== 32'h0002_000A) begin n_fail++; $display("FAIL hz_done got %h want 0002000a", q); end
    wb_read(8'h40, q);
    n_cmp++;
    if (q !== 32'h0000_0001) begin n_fail++; $display("FAIL hz_w00 got %h want 00000001", q); end
    wb_read(8'h94, q);
    e = model_res(vecs[1], 2);
    n_cmp++;
    if (q !== e) begin n_fail++; $display("FAIL hz_res1_2 got %h want %h", q, e); end
  endtask

  task automatic test_out_of_region();
    logic seen;
    seen = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0104;
    repeat (4) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0;
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL oor_ack got 1 want 0"); end
  endtask

  task automatic test_reset_mid_feed();
    logic [31:0] q, e;
    int unsigned t;
    wb_write(8'h00, 32'd2);
    for (int m = 0; m < 4; m++) wb_write(8'h08, vecs[m]);
    wb_write(8'h00, 32'd1);
    t = last_ack;
    while (cyc_n < t + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb_read(8'h04, q);
    n_cmp++;
    if (q !== 32'd0) begin n_fail++; $display("FAIL mid_rst_status got %h want 00000000", q); end
    for (int n = 0; n < 9; n++) begin
      wb_read(8'(8'h40 + 4 * n), q);
      n_cmp++;
      if (q !== 32'd0) begin n_fail++; $display("FAIL mid_rst_w%0d got %h want 00000000", n, q); end
    end
    w_model = '{2, 0, -1, 3, 1, 0, -5, 4, 6};
    load_weights();
    wb_write(8'h08, vecs[2]);
    wb_write(8'h08, vecs[3]);
    wb_write(8'h00, 32'd1);
    wait_done();
    wb_read(8'h04, q);
    n_cmp++;
    if (q !== 32'h0002_0002) begin n_fail++; $display("FAIL fresh_status got %h want 00020002", q); end
    for (int m = 0; m < 2; m++)
      for (int j = 0; j < 3; j++) exp_q.push_back(model_res(vecs[m+2], j));
    for (int n = 0; n < 6; n++) begin
      wb_read(8'(8'h80 + 4 * n), q);
      e = exp_q.pop_front();
      n_cmp++;
      if (q !== e) begin n_fail++; $display("FAIL fresh_res_%0d got %h want %h", n, q, e); end
    end
  endtask

  initial begin
    vecs = '{32'h0001_0203, 32'hAA7F_80FF, 32'h00FE_FDFC, 32'h0010_2030,
             32'h00F0_0F80, 32'h007F_7F7F, 32'h0080_8080, 32'h0000_FF01,
             32'h0011_1111};
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
    dat_i = '0; adr = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_identity();
    test_signed_extreme();
    test_clear();
    test_batch();
    test_hazards();
    test_out_of_region();
    test_reset_mid_feed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
